// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared constants and state type for the FIFO write arbiter
package fifo_wr_arbiter_pkg;
    localparam int DEF_N_REQ      = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 4;
    typedef enum logic {IDLE, BURST} arb_state_e;
endpackage

// File: rtl/fifo_rr_picker.sv
// fifo_rr_picker: first valid requester at or after rr_ptr, wrapping modulo N_REQ
module fifo_rr_picker #(
    parameter int N_REQ = 4,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GW-1:0]    rr_ptr,
    output logic             any_valid,
    output logic [GW-1:0]    pick_idx
);
    // scan from farthest to nearest so the nearest valid index wins
    always_comb begin
        any_valid = 1'b0;
        pick_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                any_valid = 1'b1;
                pick_idx  = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one registered FIFO write port
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int GW         = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        err_overflow
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d, rr_q, rr_d, pick_idx;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  wr_en_q, wr_en_d, wr_prev_q, err_q, err_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic                  any_valid, cur_valid, accept;
    logic                  unused_ack;

    assign unused_ack = fifo_wr_ack;

    fifo_rr_picker #(.N_REQ(N_REQ), .GW(GW)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_q),
        .any_valid (any_valid),
        .pick_idx  (pick_idx)
    );

    // accept decision, next state, and registered write stage inputs
    always_comb begin
        cur_valid = req_valid[grant_q];
        accept    = (state_q == BURST) & cur_valid & ~fifo_full & ~(fifo_almostfull & wr_en_q);
        req_ready = accept ? N_REQ'(1) << grant_q : '0;
        wr_en_d   = accept;
        data_d    = accept ? req_data[int'(grant_q)*FIFO_WIDTH +: FIFO_WIDTH] : data_q;
        err_d     = err_q | (fifo_overflow & wr_prev_q);
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        if (state_q == IDLE) begin
            if (any_valid) begin
                state_d = BURST;
                grant_d = pick_idx;
                rr_d    = GW'((int'(pick_idx) + 1) % N_REQ);
                beat_d  = '0;
            end
        end else if (!cur_valid) begin
            state_d = IDLE;
        end else if (accept) begin
            beat_d  = beat_q + 1'b1;
            state_d = (beat_q == BW'(MAX_BURST - 1)) ? IDLE : BURST;
        end
    end

    // state and write-stage registers; reset discards any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_prev_q <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            wr_en_q   <= wr_en_d;
            wr_prev_q <= wr_en_q;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q == BURST);
    assign err_overflow = err_q;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the sync FIFO among N_REQ producers.
- Grants one producer at a time for a bounded burst and drives the FIFO wr_en/data_in from a registered stage.
- Throttles producers using the FIFO full/almostfull flags so that, in normal operation, no write is issued into a full FIFO.
- Sits between the producer agents and the FIFO write side, in the same clock domain.

Parameters:
- N_REQ, 4, number of producers (2..8).
- FIFO_WIDTH, 16, data width; must equal the FIFO data_in width.
- MAX_BURST, 4, maximum beats accepted per grant before re-arbitration (1..16).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  producer i has a beat.
- req_data  in  N_REQ*FIFO_WIDTH  producer i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  N_REQ  beat of producer i is accepted this cycle when valid&ready.
- fifo_wr_en  out  1  registered write strobe to the FIFO.
- fifo_data_in  out  FIFO_WIDTH  registered write data.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO almost-full flag (count == depth-1).
- fifo_wr_ack  in  1  FIFO write acknowledge.
- fifo_overflow  in  1  FIFO overflow flag.
- grant_id  out  $clog2(N_REQ)  index of the current grantee; valid while busy.
- busy  out  1  high in BURST.
- err_overflow  out  1  sticky: the FIFO reported overflow for a write issued by this block.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=IDLE; rr_ptr=0; beat_cnt=0; wr_en_q=0; data_q=0.
- States:
  - IDLE: if any req_valid, pick the first valid index at or after rr_ptr (wrapping modulo N_REQ). Register grant_id, set rr_ptr=grant_id+1 mod N_REQ, beat_cnt=0, go to BURST. No beat is accepted in IDLE, so every burst starts with a one-cycle bubble.
  - BURST: req_ready[grant_id] = req_valid[grant_id] & ~fifo_full & ~(fifo_almostfull & wr_en_q). All other ready bits are 0.
- Accept (valid&ready): wr_en_q<=1 and data_q<=req_data slice on the next edge; otherwise wr_en_q<=0. Write latency is exactly 1 cycle from accept to fifo_wr_en.
- Exit BURST -> IDLE when any of these holds:
  - an accept occurs with beat_cnt==MAX_BURST-1;
  - req_valid[grant_id]==0 in BURST; the drop is seen the same cycle, no accept occurs, and the grant is released.
- Stalls on full/almostfull hold the grant and do not advance beat_cnt.
- beat_cnt is $clog2(MAX_BURST)+1 bits wide and counts accepts only.
- Simultaneous full and valid: no accept. Stall persists until the flags drop.
- err_overflow: set when fifo_overflow==1 in the cycle following fifo_wr_en==1. Cleared only by reset.
- fifo_wr_ack is informational only; a cycle with wr_en and no ack is not counted as an error.
- Reset mid-burst: the in-flight write register is discarded (wr_en=0 immediately). Priority restarts at producer 0.
- A single requester that is continuously valid receives back-to-back bursts separated by one IDLE cycle.

Decomposition:
- shared_pkg gets:
  - FIFO_WIDTH constant, reused;
  - typedef enum logic {IDLE, BURST} arb_state_e;
  - N_REQ default constant.
- Sub-module fifo_rr_picker: combinational; inputs req_valid and rr_ptr; outputs any_valid and pick_idx. It is instantiated once.

Test Plan:
- Only producer 2 valid with 6 beats, FIFO empty (depth 8) -> grant_id=2. Beats 1-4 are written, then 1 IDLE bubble, then beats 5-6. fifo_wr_en trails each accept by 1 cycle and data order is preserved.
- All 4 producers continuously valid, rr_ptr=0 -> grant order 0,1,2,3,0. Each grant carries exactly 4 accepts. There are 16 writes in 20 cycles after the first IDLE.
- FIFO held with no reads; producer 0 streams -> ready drops once almostfull&wr_en_q or full. Exactly 8 writes are accepted, fifo_overflow never asserts, and err_overflow=0.
- Producer 1 drops valid after 2 beats -> BURST->IDLE on the drop cycle. The next grant goes to the next valid index after 1 (wraps to 0 if only 0 is valid).
- rst_n asserted mid-burst (beat 2 of 4) -> fifo_wr_en, req_ready, busy, and grant_id are 0 asynchronously. After release, the first grant goes to the lowest valid index.
- Force fifo_overflow=1 one cycle after a write -> err_overflow=1 and it stays 1 until reset.
